// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider scheduler.
// Holds the FSM encoding, the configuration record and the reset configuration.
package clk_div_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int BURST_W_DEF = 8;
    localparam int MIN_PERIOD  = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_e;

    typedef struct packed {
        logic [CNT_W_DEF-1:0]   period;
        logic [CNT_W_DEF-1:0]   duty;
        logic [BURST_W_DEF-1:0] burst;
    } cfg_t;

    localparam cfg_t RESET_CFG = '{
        period: CNT_W_DEF'(2),
        duty:   CNT_W_DEF'(1),
        burst:  BURST_W_DEF'(0)
    };

    // A waveform needs at least one high and one low cycle per period.
    function automatic logic cfg_legal(input int unsigned period, input int unsigned duty);
        return (period >= MIN_PERIOD) && (duty >= 1) && (duty < period);
    endfunction

endpackage

// File: rtl/clk_div_sched_if.sv
// Configuration channel of the clock-divider scheduler (valid/ready handshake).
interface clk_div_sched_if
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_duty;
    logic [BURST_W-1:0] cfg_burst;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_duty,
        output cfg_burst,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_duty,
        input  cfg_burst,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_core.sv
// Period/duty counter: produces the registered divided waveform, the period tick
// and a combinational wrap flag on the last cycle of each period.
module clk_div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic             enable,
    input  logic             clear,
    output logic             clk_out,
    output logic             tick,
    output logic             wrap
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    assign wrap = enable && (cnt_q == period - ONE);

    // Outputs are computed from the next count so they line up with cnt_q.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + ONE;
        end
        clk_out_d = !clear && (cnt_d < duty);
        tick_d    = !clear && (cnt_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_sched.sv
// Clock-divider scheduler: FSM, configuration handshake with one pending slot,
// and burst counting around the clk_div_core period counter.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    clk_div_sched_if.slave  cfg_if,
    input  logic            start,
    input  logic            stop,
    output logic            clk_out,
    output logic            tick,
    output logic            busy,
    output logic            done,
    output logic            cfg_err
);
    localparam logic [BURST_W-1:0] BONE = BURST_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   per_q, per_d, duty_q, duty_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]   pend_per_q, pend_per_d, pend_duty_q, pend_duty_d;
    logic [BURST_W-1:0] pend_burst_q, pend_burst_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d;
    logic               done_q, done_d;
    logic               cfg_err_q, cfg_err_d;

    logic cfg_ready, xfer, legal, burst_end, wrap, core_en, core_clr;

    assign cfg_ready        = (state_q == IDLE) || !pend_vld_q;
    assign cfg_if.cfg_ready = cfg_ready;
    assign xfer             = cfg_if.cfg_valid && cfg_ready;
    assign legal            = cfg_legal(32'(cfg_if.cfg_period), 32'(cfg_if.cfg_duty));
    assign burst_end        = (burst_q != '0) && (pcnt_q == burst_q - BONE);

    assign core_en  = (state_q != IDLE);
    assign core_clr = (state_d == IDLE);

    clk_div_core #(.CNT_W(CNT_W)) u_core (
        .clk     (clk),
        .reset   (reset),
        .period  (per_q),
        .duty    (duty_q),
        .enable  (core_en),
        .clear   (core_clr),
        .clk_out (clk_out),
        .tick    (tick),
        .wrap    (wrap)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        state_d      = state_q;
        per_d        = per_q;
        duty_d       = duty_q;
        burst_d      = burst_q;
        pend_vld_d   = pend_vld_q;
        pend_per_d   = pend_per_q;
        pend_duty_d  = pend_duty_q;
        pend_burst_d = pend_burst_q;
        pcnt_d       = pcnt_q;

        case (state_q)
            IDLE:     if (start) state_d = RUN;
            RUN: begin
                if (wrap && (stop || burst_end)) state_d = IDLE;
                else if (stop)                   state_d = STOPPING;
            end
            STOPPING: if (wrap) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Burst counting restarts whenever a new configuration takes over.
        if (state_q == IDLE) begin
            pcnt_d = '0;
        end else if (wrap) begin
            if (pend_vld_q)          pcnt_d = '0;
            else if (pcnt_q != '1)   pcnt_d = pcnt_q + BONE;
        end

        if (wrap && pend_vld_q) begin
            per_d      = pend_per_q;
            duty_d     = pend_duty_q;
            burst_d    = pend_burst_q;
            pend_vld_d = 1'b0;
        end

        // A transfer can only coincide with a busy wrap when the slot is empty.
        if (xfer && legal) begin
            if (state_q == IDLE || state_d == IDLE) begin
                per_d   = cfg_if.cfg_period;
                duty_d  = cfg_if.cfg_duty;
                burst_d = cfg_if.cfg_burst;
            end else begin
                pend_per_d   = cfg_if.cfg_period;
                pend_duty_d  = cfg_if.cfg_duty;
                pend_burst_d = cfg_if.cfg_burst;
                pend_vld_d   = 1'b1;
            end
        end

        done_d    = (state_q != IDLE) && (state_d == IDLE);
        cfg_err_d = xfer && !legal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            per_q        <= CNT_W'(RESET_CFG.period);
            duty_q       <= CNT_W'(RESET_CFG.duty);
            burst_q      <= BURST_W'(RESET_CFG.burst);
            pend_vld_q   <= 1'b0;
            pend_per_q   <= '0;
            pend_duty_q  <= '0;
            pend_burst_q <= '0;
            pcnt_q       <= '0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            per_q        <= per_d;
            duty_q       <= duty_d;
            burst_q      <= burst_d;
            pend_vld_q   <= pend_vld_d;
            pend_per_q   <= pend_per_d;
            pend_duty_q  <= pend_duty_d;
            pend_burst_q <= pend_burst_d;
            pcnt_q       <= pcnt_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed and randomized bench for clk_div_sched against a cycle-level behavioural model.
module tb_clk_div_sched;

    logic clk = 1'b0;
    logic reset, start, stop;
    logic clk_out, tick, busy, done, cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_sched_if #(.CNT_W(8), .BURST_W(8)) cfg_if ();

    clk_div_sched #(.CNT_W(8), .BURST_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .cfg_if  (cfg_if),
        .start   (start),
        .stop    (stop),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy),
        .done    (done),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Behavioural model: phase within period, periods completed, active and pending configs.
    bit m_run, m_stopping, m_pend;
    int m_phase, m_periods, m_P, m_D, m_B, m_pP, m_pD, m_pB;
    bit e_clk, e_tick, e_done, e_err;

    function automatic bit m_ready();
        return !m_run || !m_pend;
    endfunction

    task automatic model_update();
        bit acc, ok, was_idle, end_run;
        int vp, vd, vb;
        vp  = int'(cfg_if.cfg_period);
        vd  = int'(cfg_if.cfg_duty);
        vb  = int'(cfg_if.cfg_burst);
        acc = cfg_if.cfg_valid && m_ready();
        ok  = (vp >= 2) && (vd >= 1) && (vd < vp);
        if (reset) begin
            m_run = 0; m_stopping = 0; m_pend = 0;
            m_phase = 0; m_periods = 0;
            m_P = 2; m_D = 1; m_B = 0;
            e_clk = 0; e_tick = 0; e_done = 0; e_err = 0;
            return;
        end
        was_idle = !m_run;
        e_done   = 0;
        end_run  = 0;
        if (was_idle) begin
            if (start) begin
                m_run = 1; m_stopping = 0; m_phase = 0; m_periods = 0;
            end
        end else if (m_phase == m_P - 1) begin
            m_periods++;
            end_run = m_stopping || stop || (m_B != 0 && m_periods == m_B);
            if (m_pend) begin
                m_P = m_pP; m_D = m_pD; m_B = m_pB; m_pend = 0; m_periods = 0;
            end
            m_phase = 0;
            if (end_run) begin
                m_run = 0; m_stopping = 0; e_done = 1;
            end
        end else begin
            m_phase++;
            if (stop) m_stopping = 1;
        end
        e_err = acc && !ok;
        if (acc && ok) begin
            if (was_idle || !m_run) begin
                m_P = vp; m_D = vd; m_B = vb;
            end else begin
                m_pP = vp; m_pD = vd; m_pB = vb; m_pend = 1;
            end
        end
        e_clk  = m_run && (m_phase < m_D);
        e_tick = m_run && (m_phase == 0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready before the edge, update the model, check registered outputs after it.
    task automatic step();
        check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_ready()));
        @(posedge clk);
        model_update();
        #1;
        check("clk_out", 32'(clk_out), 32'(e_clk));
        check("tick",    32'(tick),    32'(e_tick));
        check("busy",    32'(busy),    32'(m_run));
        check("done",    32'(done),    32'(e_done));
        check("cfg_err", 32'(cfg_err), 32'(e_err));
    endtask

    task automatic push(input int p, input int d, input int b);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = 8'(p);
        cfg_if.cfg_duty   = 8'(d);
        cfg_if.cfg_burst  = 8'(b);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k = 0;
        cfg_if.cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
        while (busy === 1'b1 && k < max) begin
            step();
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic stop_run(input string tag);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle(tag, 300);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_period = '0; cfg_if.cfg_duty = '0; cfg_if.cfg_burst = '0;
        step();
        step();
        reset = 1'b0;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick",    32'(tick),    32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_ready",   32'(cfg_if.cfg_ready), 32'd1);

        // Default config: 1,0,1,0 from the cycle after start.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t1_clk_out", 32'(clk_out), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("t1_tick",    32'(tick),    (i % 2 == 0) ? 32'd1 : 32'd0);
            check("t1_busy",    32'(busy),    32'd1);
            step();
        end
        stop_run("t1_idle");

        // Burst of two 111000 periods; done on cycle 13 after start.
        push(6, 3, 2);
        step();
        cfg_if.cfg_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            check("t2_clk_out", 32'(clk_out), (((i - 1) % 6) < 3) ? 32'd1 : 32'd0);
            check("t2_done",    32'(done),    32'd0);
            step();
        end
        check("t2_done_pulse", 32'(done),    32'd1);
        check("t2_busy_fall",  32'(busy),    32'd0);
        check("t2_clk_low",    32'(clk_out), 32'd0);
        step();
        check("t2_done_once",  32'(done),    32'd0);
        check("t2_clk_stays",  32'(clk_out), 32'd0);

        // Free-run P=5 D=2, mid-period switch to P=4 D=1 at the boundary.
        push(5, 2, 0);
        step();
        cfg_if.cfg_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        push(4, 1, 0);
        check("t3_ready_before", 32'(cfg_if.cfg_ready), 32'd1);
        step();
        cfg_if.cfg_valid = 1'b0;
        check("t3_ready_held", 32'(cfg_if.cfg_ready), 32'd0);
        check("t3_cnt3_low",   32'(clk_out), 32'd0);
        step();
        check("t3_cnt4_low",   32'(clk_out), 32'd0);
        check("t3_ready_held2", 32'(cfg_if.cfg_ready), 32'd0);
        step();
        check("t3_new_tick",   32'(tick),    32'd1);
        check("t3_new_high",   32'(clk_out), 32'd1);
        check("t3_ready_back", 32'(cfg_if.cfg_ready), 32'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            check("t3_clk_out", 32'(clk_out), (i % 4 == 0) ? 32'd1 : 32'd0);
            check("t3_tick",    32'(tick),    (i % 4 == 0) ? 32'd1 : 32'd0);
        end
        stop_run("t3_idle");

        // Illegal configs are flagged and leave the active P=4 D=1 config intact.
        push(1, 0, 0);
        step();
        cfg_if.cfg_valid = 1'b0;
        check("t4_err_p1", 32'(cfg_err), 32'd1);
        step();
        check("t4_err_clear", 32'(cfg_err), 32'd0);
        push(4, 4, 0);
        step();
        cfg_if.cfg_valid = 1'b0;
        check("t4_err_d_eq_p", 32'(cfg_err), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t4_clk_out", 32'(clk_out), (i % 4 == 0) ? 32'd1 : 32'd0);
            step();
        end
        stop_run("t4_idle");

        // Stop mid-period completes the period; start+stop together in IDLE starts.
        push(8, 4, 0);
        step();
        cfg_if.cfg_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            check("t5_clk_out", 32'(clk_out), (c < 4) ? 32'd1 : 32'd0);
            check("t5_busy",    32'(busy),    32'd1);
            check("t5_no_done", 32'(done),    32'd0);
            step();
        end
        check("t5_done",      32'(done),    32'd1);
        check("t5_idle",      32'(busy),    32'd0);
        step();
        check("t5_done_once", 32'(done),    32'd0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("t5_start_wins", 32'(busy), 32'd1);
        check("t5_start_tick", 32'(tick), 32'd1);
        stop_run("t5_idle2");

        // Reset mid-run with a pending config: everything returns to defaults.
        push(6, 3, 0);
        step();
        cfg_if.cfg_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        push(3, 1, 0);
        step();
        cfg_if.cfg_valid = 1'b0;
        step();
        check("t6_pending", 32'(cfg_if.cfg_ready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_clk_out", 32'(clk_out), 32'd0);
        check("t6_tick",    32'(tick),    32'd0);
        check("t6_busy",    32'(busy),    32'd0);
        check("t6_done",    32'(done),    32'd0);
        check("t6_ready",   32'(cfg_if.cfg_ready), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t6_default", 32'(clk_out), (i % 2 == 0) ? 32'd1 : 32'd0);
            step();
        end
        stop_run("t6_idle");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 24) == 0);
            cfg_if.cfg_valid  = ($urandom_range(0, 5) == 0);
            cfg_if.cfg_period = 8'($urandom_range(0, 10));
            cfg_if.cfg_duty   = 8'($urandom_range(0, 10));
            cfg_if.cfg_burst  = 8'($urandom_range(0, 4));
            step();
        end
        reset = 1'b0;
        stop_run("rand_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Runtime-programmable clock-divider controller: owns a period/duty counter and sequences it through start, stop and burst runs.
- Accepts new divide configurations over a valid/ready handshake. Applies them glitch-free only at period boundaries.
- Sits between the control/CSR logic and any block consuming a divided enable/clock (baud, sampling, LED timing).

Parameters:
- CNT_W, 8, width of period and duty fields; max period 2^CNT_W-1.
- BURST_W, 8, width of burst-count field; 0 means free-run.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration slot free (combinational)
- cfg_period  in  CNT_W  requested period P in clk cycles
- cfg_duty  in  CNT_W  requested high time D in clk cycles
- cfg_burst  in  BURST_W  number of periods to run, 0 = until stop
- start  in  1  begin generation (honoured in IDLE only)
- stop  in  1  graceful stop request (honoured in RUN only)
- clk_out  out  1  divided waveform, registered
- tick  out  1  one-cycle pulse at first cycle of each period, registered
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when generation ends
- cfg_err  out  1  one-cycle pulse when an accepted config is illegal

Behaviour:
- Reset values:
  - clk_out=0, tick=0, done=0, cfg_err=0, busy=0.
  - state=IDLE, cnt=0, no pending config.
  - Active config P=2, D=1, B=0.
  - Reset overrides every other input in the same cycle.
- Handshake:
  - Transfer occurs on an edge where cfg_valid && cfg_ready.
  - cfg_ready=1 in IDLE.
  - In RUN/STOPPING, cfg_ready=1 only while the pending slot is empty.
- Legality check on transfer: 2 <= P and 1 <= D <= P-1.
  - Illegal: cfg_err=1 the next cycle; config discarded, active and pending unchanged.
  - Legal in IDLE: written to active registers the next cycle.
  - Legal while busy: held in pending.
- States:
  - IDLE: clk_out=0, cnt=0. start → RUN.
  - RUN: cnt runs 0..P-1 and wraps.
    - clk_out=1 iff cnt<D; tick=1 iff cnt==0.
    - First RUN cycle is the cycle after start is sampled, with cnt=0, clk_out=1, tick=1 (latency 1).
  - STOPPING: same waveform as RUN; no new periods begin. At cnt==P-1 → IDLE.
- Period boundary (RUN, cnt==P-1):
  - If pending is valid, it becomes active for the next period, pending clears, and the period counter resets to 0.
  - Otherwise the period counter increments (saturating).
- Burst: with B!=0, at cnt==P-1 of period number B-1 → IDLE, done=1 the next cycle.
- stop in RUN:
  - → STOPPING; the current period completes.
  - done=1 in the first IDLE cycle.
  - If stop is sampled on the last cycle of a period, the next cycle is IDLE.
- Simultaneous events:
  - stop and burst-end on the same cycle: single done pulse.
  - start and stop together in IDLE: start wins.
  - stop in IDLE and start while busy: ignored.
  - Pending config still held on entry to IDLE is made active on that IDLE entry cycle.
- Return to IDLE: clk_out=0 and tick=0 on the same edge that sets done.
- Reset mid-run: output drops immediately to reset values; the pending config is lost.
- Widths:
  - cnt is CNT_W bits.
  - Period counter is BURST_W bits.
  - Comparisons are unsigned. No arithmetic overflow, since P<=2^CNT_W-1.

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, RUN, STOPPING}.
  - Packed struct cfg_t {period, duty, burst}.
  - Constants MIN_PERIOD=2, RESET_CFG.
- Sub-module clk_div_core:
  - Contents: counter, clk_out/tick generation and a wrap flag.
  - Inputs: period, duty, enable, clear.
  - The controller owns the FSM, handshake, pending slot and burst counting.

Test Plan:
1. Reset, then start with default config → clk_out pattern 1,0,1,0…; tick every 2 cycles; busy=1; first high on the cycle after start.
2. Config P=6, D=3, B=2 in IDLE, then start → two periods of 111000; done pulses once on cycle 13 after start; busy falls with it; clk_out stays 0.
3. Free-run P=5, D=2; mid-period push P=4, D=1 → cfg_ready drops until boundary; waveform 11000 finishes, then 1000 repeats; no truncated period.
4. Config P=1, D=0, and separately P=4, D=4 → cfg_err pulse each; waveform unchanged.
5. Running P=8, D=4; stop asserted at cnt=2 → period completes through cnt=7; single done; start and stop sampled together in IDLE → RUN begins.
6. Reset asserted at cnt=3 of a P=6 run with a pending config → next cycle all outputs 0, IDLE; after start the default P=2 waveform is produced.
